// File: rtl/dmem_resp.sv
// Data-memory responder: one outstanding SRAM-like access, fixed-latency load/store response.
// Optional build macro DMEM_RESP_RAND_LAT_EN adds 0..3 LFSR-chosen extra wait cycles per access.
module dmem_resp #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ext_signed,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err,
  output logic        d_stall
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              sgn_q, sgn_d;
  logic              mis_q, mis_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [4:0]        extra;
  logic              accept;
  logic              mis_in;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              unused_addr;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  assign idx         = addr[ADDR_W+1:2];
  assign unused_addr = ^addr[31:ADDR_W+2];
  assign accept      = (state_q == IDLE) && req;
  assign mis_in      = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));

`ifdef DMEM_RESP_RAND_LAT_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign extra  = {3'b000, lfsr_q[1:0]};

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign extra = 5'd0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    off_d   = off_q;
    sgn_d   = sgn_q;
    mis_d   = mis_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = wr;
          size_d  = size;
          off_d   = addr[1:0];
          sgn_d   = ext_signed;
          mis_d   = mis_in;
          word_d  = mem[idx];
          cnt_d   = 5'(LAT - 1) + extra;
          state_d = (cnt_d == 5'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 5'd1) begin
          cnt_d   = 5'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result is computed from next-cycle fields so it is registered on the edge entering RESP.
  always_comb begin
    byte_sel = 8'(word_d >> {off_d, 3'b000});
    half_sel = off_d[1] ? word_d[31:16] : word_d[15:0];
    rdata_d  = 32'd0;
    err_d    = 1'b0;
    if (state_d == RESP) begin
      err_d = mis_d;
      if (!wr_d && !mis_d) begin
        case (size_d)
          2'b00:   rdata_d = {{24{sgn_d & byte_sel[7]}}, byte_sel};
          2'b01:   rdata_d = {{16{sgn_d & half_sel[15]}}, half_sel};
          default: rdata_d = word_d;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      sgn_q   <= 1'b0;
      mis_q   <= 1'b0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      off_q   <= off_d;
      sgn_q   <= sgn_d;
      mis_q   <= mis_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Stores commit at the acceptance edge; the RAM itself is never cleared.
  always_ff @(posedge clk) begin
    if (accept && wr && !mis_in && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign addr_ok = (state_q == IDLE);
  assign data_ok = (state_q == RESP);
  assign d_stall = ((state_q == IDLE) && req) || (state_q == WAIT);
  assign rdata   = rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed loads/stores with a queued scoreboard, reset-in-WAIT and LAT=1 throughput.
module tb_dmem_resp;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr, ext_signed;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok, err, d_stall;
  logic [31:0] rdata;

  logic        req_b, wr_b, ext_signed_b;
  logic [1:0]  size_b;
  logic [3:0]  wstrb_b;
  logic [31:0] addr_b, wdata_b;
  logic        addr_ok_b, data_ok_b, err_b, d_stall_b;
  logic [31:0] rdata_b;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];
  int          acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_resp #(.ADDR_W(10), .LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .ext_signed(ext_signed), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(rdata), .err(err), .d_stall(d_stall)
  );

  dmem_resp #(.ADDR_W(10), .LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst), .req(req_b), .wr(wr_b), .size(size_b), .wstrb(wstrb_b),
    .addr(addr_b), .wdata(wdata_b), .ext_signed(ext_signed_b), .addr_ok(addr_ok_b),
    .data_ok(data_ok_b), .rdata(rdata_b), .err(err_b), .d_stall(d_stall_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per data_ok pulse.
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    int          a;
    if (!rst) begin
      if (data_ok) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_data_ok", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("rdata", rdata, e[31:0]);
          chk("err", {31'd0, err}, {31'd0, e[32]});
          chk("d_stall_resp", {31'd0, d_stall}, 32'd0);
`ifdef DMEM_RESP_RAND_LAT_EN
          chk("latency_range", {31'd0, ((cyc - a) >= LAT) && ((cyc - a) <= LAT + 3)}, 32'd1);
`else
          chk("latency", cyc - a, LAT);
`endif
        end
      end else begin
        chk("idle_outputs", rdata | {31'd0, err}, 32'd0);
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d, input logic sg,
                       input logic [31:0] exp_r, input logic exp_e);
    int k;
    @(negedge clk);
    k = 0;
    while (!addr_ok && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("addr_ok_before_req", {31'd0, addr_ok}, 32'd1);
    req = 1'b1; wr = w; size = sz; wstrb = st; addr = a; wdata = d; ext_signed = sg;
    #1;
    chk("d_stall_req", {31'd0, d_stall}, 32'd1);
    exp_q.push_back({exp_e, exp_r});
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    req = 1'b0;
    wr = 1'($urandom_range(0, 1));
    size = 2'($urandom_range(0, 3));
    wstrb = 4'($urandom_range(0, 15));
    addr = $urandom;
    wdata = $urandom;
    ext_signed = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("d_stall_wait", {31'd0, d_stall}, 32'd1);
    k = 0;
    while (exp_q.size() != 0 && k < LAT + 8) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("response_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc, ndok;
    rst = 1'b1;
    req = 1'b0; wr = 1'b0; size = 2'b10; wstrb = 4'h0; addr = '0; wdata = '0; ext_signed = 1'b0;
    req_b = 1'b0; wr_b = 1'b0; size_b = 2'b10; wstrb_b = 4'h0; addr_b = '0; wdata_b = '0;
    ext_signed_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr_ok", {31'd0, addr_ok}, 32'd1);
    chk("rst_d_stall_lo", {31'd0, d_stall}, 32'd0);
    req = 1'b1;
    #1;
    chk("rst_d_stall_hi", {31'd0, d_stall}, 32'd1);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    issue(1, 2'b10, 4'b1111, 32'h10, 32'h8765_4321, 0, 32'h0000_0000, 0);
    issue(0, 2'b10, 4'b0000, 32'h10, 32'h0,         0, 32'h8765_4321, 0);
    issue(0, 2'b00, 4'b0000, 32'h13, 32'h0,         1, 32'hFFFF_FF87, 0);
    issue(0, 2'b00, 4'b0000, 32'h13, 32'h0,         0, 32'h0000_0087, 0);
    issue(1, 2'b01, 4'b1100, 32'h12, 32'hBEEF_0000, 0, 32'h0000_0000, 0);
    issue(0, 2'b10, 4'b0000, 32'h10, 32'h0,         0, 32'hBEEF_4321, 0);
    issue(0, 2'b01, 4'b0000, 32'h12, 32'h0,         0, 32'h0000_BEEF, 0);
    issue(0, 2'b01, 4'b0000, 32'h12, 32'h0,         1, 32'hFFFF_BEEF, 0);
    issue(0, 2'b10, 4'b0000, 32'h11, 32'h0,         0, 32'h0000_0000, 1);
    issue(1, 2'b10, 4'b1111, 32'h11, 32'h0,         0, 32'h0000_0000, 1);
    issue(0, 2'b10, 4'b0000, 32'h10, 32'h0,         0, 32'hBEEF_4321, 0);
    issue(0, 2'b00, 4'b0000, 32'h10, 32'h0,         1, 32'h0000_0021, 0);
    issue(0, 2'b00, 4'b0000, 32'h11, 32'h0,         1, 32'h0000_0043, 0);
    issue(0, 2'b01, 4'b0000, 32'h10, 32'h0,         1, 32'h0000_4321, 0);
    issue(0, 2'b01, 4'b0000, 32'h13, 32'h0,         1, 32'h0000_0000, 1);
    issue(0, 2'b11, 4'b0000, 32'h10, 32'h0,         0, 32'hBEEF_4321, 0);
    issue(1, 2'b10, 4'b0000, 32'h10, 32'hFFFF_FFFF, 0, 32'h0000_0000, 0);
    issue(0, 2'b10, 4'b0000, 32'h10, 32'h0,         0, 32'hBEEF_4321, 0);
    issue(1, 2'b00, 4'b0001, 32'h20, 32'h0000_00F0, 0, 32'h0000_0000, 0);
    issue(0, 2'b00, 4'b0000, 32'h20, 32'h0,         0, 32'h0000_00F0, 0);
    issue(0, 2'b00, 4'b0000, 32'h20, 32'h0,         1, 32'hFFFF_FFF0, 0);

    // Reset while the load sits in WAIT: no response may follow.
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h10; ext_signed = 1'b0;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    chk("d_stall_before_rst", {31'd0, d_stall}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("post_rst_addr_ok", {31'd0, addr_ok}, 32'd1);
    chk("post_rst_d_stall", {31'd0, d_stall}, 32'd0);
    repeat (LAT + 4) @(negedge clk);
    chk("post_rst_no_resp", {31'd0, addr_ok}, 32'd1);
    issue(0, 2'b10, 4'b0000, 32'h10, 32'h0, 0, 32'hBEEF_4321, 0);

`ifndef DMEM_RESP_RAND_LAT_EN
    // LAT=1 instance with req held high: accept / respond alternate every cycle.
    nacc = 0;
    ndok = 0;
    @(negedge clk);
    req_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("b_d_stall", {31'd0, d_stall_b}, {31'd0, (i % 2) == 0});
      chk("b_data_ok", {31'd0, data_ok_b}, {31'd0, (i % 2) == 1});
      chk("b_addr_ok", {31'd0, addr_ok_b}, {31'd0, (i % 2) == 0});
      if (addr_ok_b) nacc++;
      if (data_ok_b) ndok++;
      @(negedge clk);
    end
    req_b = 1'b0;
    chk("b_accepts", nacc, 32'd5);
    chk("b_responses", ndok, 32'd5);
    @(negedge clk);
    chk("b_idle_after", {31'd0, data_ok_b}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
